// File: rtl/async_ring_ctrl_if.sv
// -----------------------------------------------------------------------------
// async_ring_ctrl_if
//
// Bundles the host-side control/status of the ring sequencer together with the
// 4-phase request/acknowledge pair that runs into the self-timed pipeline.
//
// Signals
//   start        host -> ctrl   single-cycle pulse, begins a run when idle
//   num_tokens   host -> ctrl   tokens to launch, sampled on accepted start
//   ring_ack     pipe -> ctrl   asynchronous acknowledge from pipeline output
//   ring_req     ctrl -> pipe   registered request into pipeline input
//   busy         ctrl -> host   high while a run is in progress
//   done         ctrl -> host   single-cycle pulse at run end
//   err          ctrl -> host   sticky error flag
//   tokens_done  ctrl -> host   completed tokens in current/last run
//   total_cycles ctrl -> host   busy cycles of current/last run, saturating
//   max_lat      ctrl -> host   worst per-token round trip, saturating
//
// Modports
//   slave  : the sequencer itself
//   master : the environment (host registers plus pipeline)
// -----------------------------------------------------------------------------
interface async_ring_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             start;
  logic [CNT_W-1:0] num_tokens;
  logic             ring_req;
  logic             ring_ack;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] tokens_done;
  logic [CNT_W-1:0] total_cycles;
  logic [CNT_W-1:0] max_lat;

  modport slave (
    input  start,
    input  num_tokens,
    input  ring_ack,
    output ring_req,
    output busy,
    output done,
    output err,
    output tokens_done,
    output total_cycles,
    output max_lat
  );

  modport master (
    output start,
    output num_tokens,
    output ring_ack,
    input  ring_req,
    input  busy,
    input  done,
    input  err,
    input  tokens_done,
    input  total_cycles,
    input  max_lat
  );

endinterface

// File: rtl/async_ring_ctrl.sv
// -----------------------------------------------------------------------------
// async_ring_ctrl
//
// Synchronous sequencer for the self-timed inverter-chain pipeline. On an
// accepted start it launches num_tokens tokens through a 4-phase
// return-to-zero handshake (req up, ack up, req down, ack down), synchronising
// the pipeline acknowledge into the clk domain first. It reports the number of
// completed tokens, total busy cycles and the worst per-token round trip.
//
// Parameters
//   SYNC_STAGES  flops in the ring_ack synchroniser (values below 2 use 2)
//   CNT_W        width of the token count and every cycle counter
//   TIMEOUT      cycles a handshake phase may last before the run aborts
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    async_ring_ctrl_if.slave (host control/status + ring handshake)
// -----------------------------------------------------------------------------
module async_ring_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  async_ring_ctrl_if.slave  bus
);

  // A single flop gives no metastability settling time, so the chain never
  // gets shorter than two stages.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // The phase counter starts at 0 on entry, so its last permitted value is
  // TIMEOUT-1; a phase therefore lasts at most TIMEOUT cycles.
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_FALL,
    ST_FIN
  } state_t;

  state_t           state;
  logic [SYNC_N-1:0] sync_q;
  logic             ack_s;

  logic             ring_req_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] tokens_done_q;
  logic [CNT_W-1:0] total_cycles_q;
  logic [CNT_W-1:0] max_lat_q;

  logic [CNT_W-1:0] target;     // token count latched on accepted start
  logic [CNT_W-1:0] phase_cnt;  // cycles spent in the current state
  logic [CNT_W-1:0] tok_cnt;    // cycles spent on the current token

  logic [CNT_W:0]   next_done;  // one bit wider so the compare cannot wrap
  logic             more_tokens;
  logic             phase_expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // ring_ack synchroniser. ring_ack is never looked at anywhere else.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its neighbour held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], bus.ring_ack};
    end
  end

  assign ack_s = sync_q[SYNC_N-1];

  // ---------------------------------------------------------------------------
  // Small decode feeding the state machine.
  // ---------------------------------------------------------------------------
  assign next_done     = {1'b0, tokens_done_q} + 1'b1;
  assign more_tokens   = next_done < {1'b0, target};
  assign phase_expired = phase_cnt == PHASE_LAST;

  // ---------------------------------------------------------------------------
  // Sequencer. Every output is a flop so the pipeline and the host only ever
  // see glitch-free levels.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ring_req_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      tokens_done_q  <= '0;
      total_cycles_q <= '0;
      max_lat_q      <= '0;
      target         <= '0;
      phase_cnt      <= '0;
      tok_cnt        <= '0;
    end else begin
      done_q <= 1'b0;

      if (busy_q) begin
        total_cycles_q <= sat_inc(total_cycles_q);
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (ack_s) begin
              // The pipeline still holds a token from an earlier run: refuse
              // to start, leaving the previous results untouched.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              err_q          <= 1'b0;
              busy_q         <= 1'b1;
              tokens_done_q  <= '0;
              total_cycles_q <= '0;
              max_lat_q      <= '0;
              target         <= bus.num_tokens;
              phase_cnt      <= '0;
              tok_cnt        <= CNT_W'(1);
              if (bus.num_tokens == '0) begin
                state <= ST_FIN;
              end else begin
                state      <= ST_RISE;
                ring_req_q <= 1'b1;
              end
            end
          end
        end

        ST_RISE: begin
          tok_cnt <= sat_inc(tok_cnt);
          if (ack_s) begin
            state      <= ST_FALL;
            ring_req_q <= 1'b0;
            phase_cnt  <= '0;
          end else if (phase_expired) begin
            err_q      <= 1'b1;
            ring_req_q <= 1'b0;
            state      <= ST_FIN;
            phase_cnt  <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_FALL: begin
          tok_cnt <= sat_inc(tok_cnt);
          if (!ack_s) begin
            // Handshake complete. tok_cnt already includes this exit cycle.
            tokens_done_q <= next_done[CNT_W-1:0];
            if (tok_cnt > max_lat_q) begin
              max_lat_q <= tok_cnt;
            end
            phase_cnt <= '0;
            if (more_tokens) begin
              state      <= ST_RISE;
              ring_req_q <= 1'b1;
              tok_cnt    <= CNT_W'(1);
            end else begin
              state <= ST_FIN;
            end
          end else if (phase_expired) begin
            err_q     <= 1'b1;
            state     <= ST_FIN;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_FIN: begin
          ring_req_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          phase_cnt  <= '0;
          state      <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          ring_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ring_req     = ring_req_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.tokens_done  = tokens_done_q;
  assign bus.total_cycles = total_cycles_q;
  assign bus.max_lat      = max_lat_q;

endmodule

// File: tb/tb_async_ring_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_ring_ctrl
//
// Drives async_ring_ctrl through directed and randomised runs. The pipeline is
// a delay line: ring_ack follows ring_req a programmable number of cycles
// later, and can be forced high or held low. Expected results come from the
// closed-form run timing: each token takes 2*(delay+SYNC_STAGES+1) cycles,
// busy lasts tokens*latency+1 cycles and done appears one cycle after that.
// -----------------------------------------------------------------------------
module tb_async_ring_ctrl;

  localparam int S   = 2;
  localparam int CW  = 16;
  localparam int TO  = 15;

  logic clk;
  logic rst_n;

  async_ring_ctrl_if #(.CNT_W(CW)) bus ();

  async_ring_ctrl #(
    .SYNC_STAGES (S),
    .CNT_W       (CW),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Pipeline model and output monitor (sampled on the falling edge).
  // ---------------------------------------------------------------------------
  logic [15:0] hist     = '0;
  logic [3:0]  ack_delay = 4'd4;
  logic        ack_force = 1'b0;
  logic        ack_mute  = 1'b0;
  int          done_cnt  = 0;
  int          rise_cnt  = 0;
  logic        req_prev  = 1'b0;

  assign bus.ring_ack = ack_force | (~ack_mute & hist[ack_delay]);

  always @(negedge clk) begin
    hist <= {hist[14:0], bus.ring_req};
    if (bus.done === 1'b1) done_cnt++;
    if (bus.ring_req === 1'b1 && req_prev === 1'b0) rise_cnt++;
    req_prev = bus.ring_req;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns in cycle 1 of the run.
  task automatic launch(input int n);
    bus.num_tokens = CW'(n);
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  // Called in cycle 1; returns the run-relative cycle in which done is seen,
  // or -1 once the budget runs out.
  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int c = 1; c <= budget; c++) begin
      if (bus.done === 1'b1) begin
        at = c;
        break;
      end
      step();
    end
  endtask

  function automatic int lat(input int d);
    return 2 * (d + S + 1);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(bus.ring_req),     0);
    check({tag, "_busy"},  32'(bus.busy),         0);
    check({tag, "_done"},  32'(bus.done),         0);
    check({tag, "_err"},   32'(bus.err),          0);
    check({tag, "_tok"},   32'(bus.tokens_done),  0);
    check({tag, "_total"}, 32'(bus.total_cycles), 0);
    check({tag, "_lat"},   32'(bus.max_lat),      0);
  endtask

  // One clean run of n tokens through a pipeline of delay d.
  task automatic run_check(input string tag, input int n, input int d);
    int d0, r0, at, l;
    ack_delay = 4'(d);
    repeat (10) step();
    l  = lat(d);
    d0 = done_cnt;
    r0 = rise_cnt;
    launch(n);
    check({tag, "_busy1"}, 32'(bus.busy), 1);
    check({tag, "_req1"},  32'(bus.ring_req), (n > 0) ? 1 : 0);
    wait_done(n * l + 50, at);
    check({tag, "_done_at"}, 32'(at), n * l + 2);
    check({tag, "_tok"},     32'(bus.tokens_done), n);
    check({tag, "_total"},   32'(bus.total_cycles), n * l + 1);
    check({tag, "_lat"},     32'(bus.max_lat), (n > 0) ? l : 0);
    check({tag, "_err"},     32'(bus.err), 0);
    check({tag, "_busy_end"}, 32'(bus.busy), 0);
    repeat (3) step();
    check({tag, "_npulse"}, 32'(done_cnt - d0), 1);
    check({tag, "_nrise"},  32'(rise_cnt - r0), n);
    check({tag, "_req_end"}, 32'(bus.ring_req), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int d0, r0, at;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.num_tokens = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();
    check_all_zero("post_reset");

    // Reference run: 4-cycle ack delay, three tokens, latency 14
    run_check("n3_d4", 3, 4);

    // Zero-token run
    run_check("n0", 0, 4);

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      int n, d;
      n = int'($urandom_range(1, 6));
      d = int'($urandom_range(0, 8));
      run_check($sformatf("rnd%0d_n%0d_d%0d", r, n, d), n, d);
    end

    // Pipeline never acknowledges: RISE times out after TO cycles
    ack_delay = 4'd4;
    ack_mute  = 1'b1;
    repeat (10) step();
    d0 = done_cnt;
    r0 = rise_cnt;
    launch(1);
    wait_done(60, at);
    check("to_done_at", 32'(at), TO + 2);
    check("to_err",     32'(bus.err), 1);
    check("to_tok",     32'(bus.tokens_done), 0);
    check("to_total",   32'(bus.total_cycles), TO + 1);
    check("to_lat",     32'(bus.max_lat), 0);
    repeat (3) step();
    check("to_req_end", 32'(bus.ring_req), 0);
    check("to_npulse",  32'(done_cnt - d0), 1);
    check("to_nrise",   32'(rise_cnt - r0), 1);
    ack_mute = 1'b0;

    // ring_ack high before start: rejected, done next cycle, no request
    ack_force = 1'b1;
    repeat (S + 2) step();
    d0 = done_cnt;
    r0 = rise_cnt;
    launch(1);
    check("ackhi_done", 32'(bus.done), 1);
    check("ackhi_err",  32'(bus.err), 1);
    check("ackhi_busy", 32'(bus.busy), 0);
    check("ackhi_req",  32'(bus.ring_req), 0);
    repeat (5) step();
    check("ackhi_nrise",  32'(rise_cnt - r0), 0);
    check("ackhi_npulse", 32'(done_cnt - d0), 1);
    check("ackhi_err_sticky", 32'(bus.err), 1);
    ack_force = 1'b0;
    repeat (10) step();
    launch(1);
    check("ackhi_restart_err", 32'(bus.err), 0);
    check("ackhi_restart_busy", 32'(bus.busy), 1);
    wait_done(100, at);
    check("ackhi_restart_done_at", 32'(at), lat(4) + 2);
    check("ackhi_restart_tok",     32'(bus.tokens_done), 1);

    // start again mid-run is ignored: five tokens, one done
    ack_delay = 4'd2;
    repeat (10) step();
    d0 = done_cnt;
    launch(5);
    repeat (12) step();
    bus.num_tokens = CW'(2);
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    // now in run cycle 14; wait_done counts this cycle as 1
    wait_done(200, at);
    check("mid_done_at", 32'(at), 5 * lat(2) + 2 - 13);
    check("mid_tok",     32'(bus.tokens_done), 5);
    check("mid_total",   32'(bus.total_cycles), 5 * lat(2) + 1);
    check("mid_lat",     32'(bus.max_lat), lat(2));
    check("mid_err",     32'(bus.err), 0);
    repeat (3) step();
    check("mid_npulse",  32'(done_cnt - d0), 1);

    // Reset during FALL while the pipeline still holds ack high
    ack_delay = 4'd4;
    repeat (10) step();
    launch(3);
    repeat (8) step();
    // run cycle 9: first token is in its falling phase
    check("rst_pre_busy", 32'(bus.busy), 1);
    check("rst_pre_req",  32'(bus.ring_req), 0);
    ack_force = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (S + 2) step();
    d0 = done_cnt;
    launch(2);
    check("rst_ackhi_err",  32'(bus.err), 1);
    check("rst_ackhi_done", 32'(bus.done), 1);
    check("rst_ackhi_busy", 32'(bus.busy), 0);
    ack_force = 1'b0;
    repeat (12) step();
    launch(2);
    check("rst_restart_err", 32'(bus.err), 0);
    wait_done(200, at);
    check("rst_restart_done_at", 32'(at), 2 * lat(4) + 2);
    check("rst_restart_tok",     32'(bus.tokens_done), 2);
    check("rst_restart_lat",     32'(bus.max_lat), lat(4));
    check("rst_restart_err_end", 32'(bus.err), 0);
    repeat (3) step();
    check("rst_npulse", 32'(done_cnt - d0), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_ring_ctrl.md
# async_ring_ctrl

Synchronous sequencer for the self-timed inverter-chain pipeline, intended for a depth of 32 stages. It launches a programmed number of tokens into the pipeline using a 4-phase return-to-zero handshake. It synchronises the pipeline's asynchronous acknowledge into the clock domain and reports token count, total elapsed cycles and worst-case per-token latency. It sits between the host register interface and the asynchronous pipeline top, replacing the free-running tie-off loop.

## Interface
- SYNC_STAGES, 2, flops in the `ring_ack` synchroniser (minimum 2)
- CNT_W, 16, width of token count and all cycle counters
- TIMEOUT, 1023, maximum cycles allowed per handshake phase before error (must be < 2^CNT_W)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a run when idle
- num_tokens  in  CNT_W  tokens to launch; sampled on accepted `start`
- ring_req  out  1  registered request into pipeline input
- ring_ack  in  1  asynchronous acknowledge from pipeline output; never sampled unsynchronised
- busy  out  1  high from accepted `start` until run ends
- done  out  1  single-cycle pulse at run end (success or error)
- err  out  1  sticky; set on timeout or ack-high-at-start; cleared by next accepted `start`
- tokens_done  out  CNT_W  completed tokens in current/last run
- total_cycles  out  CNT_W  cycles from `start` acceptance to `done`, saturating
- max_lat  out  CNT_W  largest per-token round trip, saturating

## Operation
- The synchroniser is a chain of SYNC_STAGES flops, reset to 0. Its output is `ack_s`.
- States: IDLE, RISE, FALL, FIN.
- IDLE:
  - `start` with `ack_s`=1: set `err`, pulse `done`, stay in IDLE, and launch no token.
  - `start` with `ack_s`=0 and `num_tokens`=0: go to FIN. Clear the counters, clear `err`, and latch the target.
  - `start` with `ack_s`=0 and `num_tokens`>0: go to RISE. Clear the counters, clear `err`, and latch the target.
- RISE: `ring_req`=1. Wait for `ack_s`=1, then go to FALL. If the phase counter reaches TIMEOUT, set `err` and go to FIN.
- FALL: `ring_req`=0. Wait for `ack_s`=0, then do all of the following in the same cycle:
  - increment `tokens_done`;
  - update `max_lat` with the token counter;
  - go to RISE if `tokens_done`+1 < target, otherwise go to FIN.
  - Timeout in this phase is handled the same way as in RISE.
- FIN: `ring_req`=0, pulse `done`, return to IDLE. `busy` is 0 from the next cycle.
- The phase counter resets on every state entry.
- The token counter counts from RISE entry through FALL exit, inclusive of the exit cycle, and saturates at all-ones.
- `total_cycles` increments every cycle while `busy`=1 and saturates at all-ones.
- `start` while `busy`=1 is ignored, with no effect on counters or `err`.
- Reset mid-run:
  - all outputs return to reset values immediately;
  - `ring_req` drops to 0 and the pipeline drains freely;
  - the next `start` is rejected with `err` if `ack_s` is still 1.
- Reset values: `ring_req`, `busy`, `done` and `err` are 0. `tokens_done`, `total_cycles` and `max_lat` are 0. State is IDLE.

## Timing
- `start` is accepted at edge 0. `busy` and `ring_req` are 1 after edge 0, i.e. cycle 1.
- `ring_ack` rising at cycle k is seen as `ack_s` at cycle k+SYNC_STAGES. `ring_req` falls one cycle after that.
- Minimum per-token latency with an instantaneous pipeline is 2×(SYNC_STAGES+1) cycles, i.e. 6 at default.
- `done` is asserted for exactly one cycle, in the cycle after the last FALL exit (the FIN cycle).
- `tokens_done`, `total_cycles` and `max_lat` are stable and valid while `done`=1 and hold until the next accepted `start`.
- Zero-token run: `done` at cycle 2, `total_cycles`=1, `ring_req` never asserted.
- Outputs are glitch-free registers; `ring_req` is driven directly from a flop.

## Test plan
- Behavioural pipeline model with 4-cycle ack delay per edge, `num_tokens`=3:
  - `ring_req` toggles 3 times high and returns low;
  - `tokens_done`=3 and `err`=0;
  - `max_lat`=2×(4+SYNC_STAGES+1)=14, one `done` pulse.
- `num_tokens`=0: `done` at cycle 2, `ring_req` stays 0, `total_cycles`=1, `err`=0.
- Model never returns ack, TIMEOUT=15:
  - `err`=1 and `done` pulses 16 cycles after RISE entry;
  - `tokens_done`=0 and `ring_req`=0 afterwards.
- `ring_ack` held 1 before `start`: `err`=1, `done` pulse next cycle, `ring_req` never rises. Releasing ack and restarting with `num_tokens`=1 clears `err`.
- `start` pulsed again mid-run with `num_tokens`=2 (original 5): run completes with `tokens_done`=5 and a single `done`.
- `rst_n` asserted during FALL with pipeline ack still high: all outputs 0 immediately. After reset release, `start` with ack still high gives `err`=1. After ack drops, the restart succeeds.
